// File: rtl/moving_average_mc_pkg.sv
// Shared defaults, width helper and per-channel state record for the
// multi-channel moving-average block.
package moving_average_mc_pkg;

   localparam int DEF_DATA_W   = 16;
   localparam int DEF_CHANNELS = 4;
   localparam int DEF_MAX_LOG2 = 4;

   // Ceiling log2 with a floor of 1 so single-entry fields still get a bit.
   function automatic int clog2(input int value);
      int r;
      r = 1;
      for (int i = 1; i < 31; i++) begin
         if ((32'sd1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

   typedef struct packed {
      logic signed [DEF_DATA_W+DEF_MAX_LOG2-1:0] sum;
      logic        [DEF_MAX_LOG2:0]              count;
      logic        [DEF_MAX_LOG2-1:0]            ptr;
   } ch_state_t;

endpackage

// File: rtl/moving_average_mc_history.sv
// Sample history storage: one write port, one combinational read port,
// addressed {channel, index}. Contents are never reset.
module ma_history_ram #(
   parameter int DATA_W  = 16,
   parameter int ADDR_W  = 6,
   parameter int ENTRIES = 64
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [ENTRIES];

   // Write port; stale entries are harmless because reads are gated by fill count.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/moving_average_mc.sv
// Interleaved multi-channel moving average over a power-of-two window with a
// running sum per channel and a one-deep registered output stage.
module moving_average_mc
   import moving_average_mc_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int CHANNELS = DEF_CHANNELS,
   parameter int MAX_LOG2 = DEF_MAX_LOG2
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                clear,
   input  logic [clog2(MAX_LOG2+1)-1:0]        win_log2,
   input  logic                                in_valid,
   output logic                                in_ready,
   input  logic [clog2(CHANNELS)-1:0]          in_ch,
   input  logic signed [DATA_W-1:0]            in_data,
   output logic                                out_valid,
   input  logic                                out_ready,
   output logic [clog2(CHANNELS)-1:0]          out_ch,
   output logic signed [DATA_W-1:0]            out_data,
   output logic                                out_full
);

   localparam int WW    = clog2(MAX_LOG2 + 1);
   localparam int CH_W  = clog2(CHANNELS);
   localparam int DEPTH = 1 << MAX_LOG2;
   localparam int SUM_W = DATA_W + MAX_LOG2;
   localparam int CNT_W = MAX_LOG2 + 1;

   logic [WW-1:0]           win;
   logic signed [SUM_W-1:0] sum   [CHANNELS];
   logic [CNT_W-1:0]        count [CHANNELS];
   logic [MAX_LOG2-1:0]     ptr   [CHANNELS];

   logic                    ch_ok;
   logic                    accept;
   logic [CH_W-1:0]         ch_idx;
   logic [CNT_W-1:0]        win_n;
   logic                    full_before;
   logic [MAX_LOG2-1:0]     rd_idx;
   logic [DATA_W-1:0]       rd_data;
   logic signed [SUM_W-1:0] departing;
   logic signed [SUM_W-1:0] in_ext;
   logic signed [SUM_W-1:0] sum_new;
   logic [CNT_W-1:0]        count_new;
   logic [WW-1:0]           win_clamped;

   assign in_ready    = !rst && !clear && (!out_valid || out_ready);
   assign ch_ok       = ({1'b0, in_ch} < (CH_W+1)'(CHANNELS));
   assign accept      = in_valid && in_ready && ch_ok;
   assign ch_idx      = ch_ok ? in_ch : '0;
   assign win_n       = CNT_W'(1) << win;
   assign full_before = (count[ch_idx] == win_n);
   // 2^W wraps to 0 at the maximum window, which selects the slot being overwritten.
   assign rd_idx      = ptr[ch_idx] - win_n[MAX_LOG2-1:0];
   assign in_ext      = {{MAX_LOG2{in_data[DATA_W-1]}}, in_data};
   assign departing   = full_before ? {{MAX_LOG2{rd_data[DATA_W-1]}}, rd_data} : '0;
   assign sum_new     = sum[ch_idx] + in_ext - departing;
   assign count_new   = full_before ? count[ch_idx] : count[ch_idx] + CNT_W'(1);
   assign win_clamped = (win_log2 > WW'(MAX_LOG2)) ? WW'(MAX_LOG2) : win_log2;

   ma_history_ram #(
      .DATA_W  (DATA_W),
      .ADDR_W  (CH_W + MAX_LOG2),
      .ENTRIES (CHANNELS * DEPTH)
   ) u_hist (
      .clk   (clk),
      .we    (accept),
      .waddr ({ch_idx, ptr[ch_idx]}),
      .wdata (in_data),
      .raddr ({ch_idx, rd_idx}),
      .rdata (rd_data)
   );

   // Channel state and window exponent.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         win <= WW'(MAX_LOG2);
         for (int c = 0; c < CHANNELS; c++) begin
            sum[c]   <= '0;
            count[c] <= '0;
            ptr[c]   <= '0;
         end
      end else if (clear) begin
         win <= win_clamped;
         for (int c = 0; c < CHANNELS; c++) begin
            sum[c]   <= '0;
            count[c] <= '0;
            ptr[c]   <= '0;
         end
      end else if (accept) begin
         sum[ch_idx]   <= sum_new;
         count[ch_idx] <= count_new;
         ptr[ch_idx]   <= ptr[ch_idx] + MAX_LOG2'(1);
      end
   end

   // Output stage: load on accepted sample, drain on handshake, else hold.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_ch    <= '0;
         out_data  <= '0;
         out_full  <= 1'b0;
      end else if (accept) begin
         out_valid <= 1'b1;
         out_ch    <= ch_idx;
         out_data  <= DATA_W'(sum_new >>> win);
         out_full  <= (count_new == win_n);
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule
